// File: rtl/ram_handshake_unit.sv
// ram_handshake_unit
//
// Byte-addressable 2**ADDR_W-byte memory with a multi-cycle MFA/MFC handshake.
// This block sits downstream of the datapath. It takes MAR as Address, MDR as
// DataIn, and the datapath's size selector as DataSize. It returns read data
// to the IR / sign-extension path and MFC to the control unit.
//
// The handshake runs as follows:
// - A request is captured on the first edge that sees MFA high in IDLE.
// - WAIT_CYCLES wait cycles follow.
// - One ACCESS cycle then does the read or write and raises MFC.
// - MFC stays high until MFA is seen low.
//
// Counting the capture edge as edge 1, MFC is first visible after
// WAIT_CYCLES+2 rising edges.
//
// Byte order is big-endian. A word at A spans mem[A] (bits 31:24) through
// mem[A+3] (bits 7:0).
//
// Optional build macro: RAM_ALIGN_CHECK_EN
// - Defined: misaligned halfword/word accesses are rejected. There is no
//   write, DataOut is unchanged, and ERR=1 alongside MFC.
// - Undefined: the low address bits are forced to alignment, and ERR stays 0.
//
// Parameters:
//   WAIT_CYCLES  wait cycles between capture and access (0..15)
//   ADDR_W       address width, memory depth 2**ADDR_W bytes
//
// Ports:
//   CLK       system clock, rising edge
//   CLR       synchronous active-low reset (memory contents are kept)
//   MFA       request, held high by the master until MFC is seen
//   RW_RAM    1 = read, 0 = write (sampled at capture)
//   Address   byte address (sampled at capture)
//   DataIn    write data (sampled at capture)
//   DataSize  00 byte, 01 halfword, 10/11 word (sampled at capture)
//   DataOut   registered read data, zero-extended
//   MFC       memory function complete, registered
//   ERR       misaligned-access flag, valid while MFC = 1

module ram_handshake_unit #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              MFA,
  input  logic              RW_RAM,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  input  logic [1:0]        DataSize,
  output logic [31:0]       DataOut,
  output logic              MFC,
  output logic              ERR
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAccess,
    StDone
  } state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        size_q;
  logic              rd_q;

  logic [7:0] mem [Depth];

  // Decoded view of the captured request
  logic              is_half;
  logic              is_word;
  logic              misalign;
  logic [ADDR_W-1:0] ea0;
  logic [ADDR_W-1:0] ea1;
  logic [ADDR_W-1:0] ea2;
  logic [ADDR_W-1:0] ea3;
  logic [31:0]       rdata;

  always_comb begin
    is_word = size_q[1];
    is_half = (size_q == 2'b01);
`ifdef RAM_ALIGN_CHECK_EN
    misalign = (is_half && addr_q[0]) || (is_word && (addr_q[1:0] != 2'b00));
    ea0      = addr_q;
`else
    misalign = 1'b0;
    ea0      = addr_q;
    if (is_word) begin
      ea0[1:0] = 2'b00;
    end else if (is_half) begin
      ea0[0] = 1'b0;
    end
`endif
    // Wrap modulo the memory depth; aligned accesses never actually wrap
    ea1 = ea0 + ADDR_W'(1);
    ea2 = ea0 + ADDR_W'(2);
    ea3 = ea0 + ADDR_W'(3);

    if (is_word) begin
      rdata = {mem[ea0], mem[ea1], mem[ea2], mem[ea3]};
    end else if (is_half) begin
      rdata = {16'h0000, mem[ea0], mem[ea1]};
    end else begin
      rdata = {24'h000000, mem[ea0]};
    end
  end

  // Handshake FSM with registered outputs and the memory write port.
  // The memory write only happens in StAccess outside reset, so a reset
  // that lands mid-access drops the pending write.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      MFC     <= 1'b0;
      ERR     <= 1'b0;
      DataOut <= 32'h0000_0000;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (MFA) begin
            addr_q  <= Address;
            wdata_q <= DataIn;
            size_q  <= DataSize;
            rd_q    <= RW_RAM;
            cnt_q   <= 4'(WAIT_CYCLES);
            state_q <= (WAIT_CYCLES == 0) ? StAccess : StWait;
          end
        end

        StWait: begin
          // Leave on the edge that sees the counter at 1.
          // The <= also guards against a stray zero count.
          if (cnt_q <= 4'd1) begin
            state_q <= StAccess;
          end
          cnt_q <= cnt_q - 4'd1;
        end

        StAccess: begin
          MFC     <= 1'b1;
          ERR     <= misalign;
          state_q <= StDone;
          if (!misalign) begin
            if (rd_q) begin
              DataOut <= rdata;
            end else if (is_word) begin
              mem[ea0] <= wdata_q[31:24];
              mem[ea1] <= wdata_q[23:16];
              mem[ea2] <= wdata_q[15:8];
              mem[ea3] <= wdata_q[7:0];
            end else if (is_half) begin
              mem[ea0] <= wdata_q[15:8];
              mem[ea1] <= wdata_q[7:0];
            end else begin
              mem[ea0] <= wdata_q[7:0];
            end
          end
        end

        StDone: begin
          // If MFA already fell before MFC, this exits after one MFC cycle
          if (!MFA) begin
            MFC     <= 1'b0;
            ERR     <= 1'b0;
            state_q <= StIdle;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_handshake_unit.sv
module tb_ram_handshake_unit;

  localparam int WC = 2;

  logic        CLK;
  logic        CLR;
  logic        MFA;
  logic        RW_RAM;
  logic [7:0]  Address;
  logic [31:0] DataIn;
  logic [1:0]  DataSize;
  logic [31:0] DataOut;
  logic        MFC;
  logic        ERR;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain byte array plus the last value DataOut should hold
  logic [7:0]  mdl [256];
  logic [31:0] exp_dout;

  ram_handshake_unit #(
    .WAIT_CYCLES(WC),
    .ADDR_W     (8)
  ) dut (
    .CLK     (CLK),
    .CLR     (CLR),
    .MFA     (MFA),
    .RW_RAM  (RW_RAM),
    .Address (Address),
    .DataIn  (DataIn),
    .DataSize(DataSize),
    .DataOut (DataOut),
    .MFC     (MFC),
    .ERR     (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Applies the memory rules to the model and predicts DataOut/ERR
  task automatic model_access(input bit rd, input int a, input logic [31:0] d,
                              input logic [1:0] sz, output logic [31:0] exp_out,
                              output logic exp_err);
    int n;
    int ea;
    bit mis;
    logic [31:0] val;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
`ifdef RAM_ALIGN_CHECK_EN
    mis = (a % n) != 0;
    ea  = a;
`else
    mis = 1'b0;
    ea  = a - (a % n);
`endif
    exp_err = mis;
    if (!mis) begin
      if (rd) begin
        val = 32'h0;
        for (int i = 0; i < n; i++) val = (val << 8) | 32'(mdl[(ea + i) % 256]);
        exp_dout = val;
      end else begin
        for (int i = 0; i < n; i++) mdl[(ea + i) % 256] = 8'(d >> (8 * (n - 1 - i)));
      end
    end
    exp_out = exp_dout;
  endtask

  // One full handshake:
  // - hold: cycles MFA stays high after MFC.
  // - early: MFA drops one cycle after capture.
  task automatic access(input bit rd, input int a, input logic [31:0] d, input logic [1:0] sz,
                        input int hold, input bit early, output logic [31:0] got);
    logic [31:0] eo;
    logic        ee;
    int          edges;
    model_access(rd, a, d, sz, eo, ee);
    @(negedge CLK);
    MFA      = 1'b1;
    RW_RAM   = rd;
    Address  = 8'(a);
    DataIn   = d;
    DataSize = sz;
    @(posedge CLK);
    #1;
    edges = 1;
    // Captured values must be used from here on; scramble the live inputs
    RW_RAM   = 1'($urandom);
    Address  = 8'($urandom);
    DataIn   = $urandom;
    DataSize = 2'($urandom);
    if (early) MFA = 1'b0;
    while (!MFC && edges < 40) begin
      @(posedge CLK);
      #1;
      edges++;
    end
    check_eq("latency", edges, WC + 2);
    check_eq("mfc_high", {31'h0, MFC}, 32'h1);
    check_eq("dout", DataOut, eo);
    check_eq("err", {31'h0, ERR}, {31'h0, ee});
    got = DataOut;
    if (!early) begin
      repeat (hold) begin
        @(posedge CLK);
        #1;
        check_eq("hold_mfc", {31'h0, MFC}, 32'h1);
        check_eq("hold_dout", DataOut, eo);
        check_eq("hold_err", {31'h0, ERR}, {31'h0, ee});
      end
      MFA = 1'b0;
    end
    @(posedge CLK);
    #1;
    check_eq(early ? "pulse_width" : "mfc_release", {31'h0, MFC}, 32'h0);
    check_eq("err_release", {31'h0, ERR}, 32'h0);
    check_eq("dout_retained", DataOut, eo);
  endtask

  logic [31:0] got;

  initial begin
    CLR      = 1'b0;
    MFA      = 1'b0;
    RW_RAM   = 1'b0;
    Address  = 8'h00;
    DataIn   = 32'h0;
    DataSize = 2'b00;
    exp_dout = 32'h0;
    for (int i = 0; i < 256; i++) mdl[i] = 8'h00;

    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_mfc", {31'h0, MFC}, 32'h0);
    check_eq("rst_err", {31'h0, ERR}, 32'h0);
    check_eq("rst_dout", DataOut, 32'h0);
    CLR = 1'b1;

    // Define every byte so the model never depends on power-up contents
    for (int a = 0; a < 256; a += 4) access(1'b0, a, 32'h0, 2'b10, 0, 1'b0, got);

    // Word write then read, sizes and endianness
    access(1'b0, 'h10, 32'hDEADBEEF, 2'b10, 0, 1'b0, got);
    access(1'b1, 'h10, 32'h0, 2'b10, 0, 1'b0, got);
    check_eq("word_rd_10", got, 32'hDEADBEEF);
    access(1'b1, 'h10, 32'h0, 2'b00, 0, 1'b0, got);
    check_eq("byte_rd_10", got, 32'h000000DE);
    access(1'b1, 'h13, 32'h0, 2'b00, 0, 1'b0, got);
    check_eq("byte_rd_13", got, 32'h000000EF);
    access(1'b1, 'h12, 32'h0, 2'b01, 0, 1'b0, got);
    check_eq("half_rd_12", got, 32'h0000BEEF);
    access(1'b0, 'h11, 32'h123456AA, 2'b00, 0, 1'b0, got);
    access(1'b1, 'h10, 32'h0, 2'b10, 5, 1'b0, got);
    check_eq("word_rd_after_byte_wr", got, 32'hDEAABEEF);
    access(1'b1, 'h10, 32'h0, 2'b11, 0, 1'b0, got);
    check_eq("size11_as_word", got, 32'hDEAABEEF);

    // Early MFA drop on a write still commits
    access(1'b0, 'h30, 32'h00000055, 2'b00, 0, 1'b1, got);
    access(1'b1, 'h30, 32'h0, 2'b00, 0, 1'b0, got);
    check_eq("early_drop_commit", got, 32'h00000055);

    // Reset mid-WAIT drops a pending write
    @(negedge CLK);
    MFA      = 1'b1;
    RW_RAM   = 1'b0;
    Address  = 8'h20;
    DataIn   = 32'h11223344;
    DataSize = 2'b10;
    @(posedge CLK);
    #1;
    MFA = 1'b0;
    CLR = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_eq("midrst_mfc", {31'h0, MFC}, 32'h0);
    check_eq("midrst_dout", DataOut, 32'h0);
    exp_dout = 32'h0;
    CLR = 1'b1;
    access(1'b1, 'h20, 32'h0, 2'b10, 0, 1'b0, got);
    check_eq("midrst_no_write", got, 32'h00000000);

    // Misaligned word write
    access(1'b0, 'h41, 32'hCAFEF00D, 2'b10, 1, 1'b0, got);
    access(1'b1, 'h40, 32'h0, 2'b10, 0, 1'b0, got);
`ifdef RAM_ALIGN_CHECK_EN
    check_eq("misalign_no_write", got, 32'h00000000);
`else
    check_eq("misalign_forced", got, 32'hCAFEF00D);
`endif

    // Randomized accesses against the model
    for (int k = 0; k < 80; k++) begin
      access(1'($urandom), int'($urandom_range(0, 255)), $urandom, 2'($urandom),
             int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), got);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
